// File: rtl/x_delay_line_meas.sv
// Delay-line edge-position meter: decodes each snapshot, accumulates min/max/avg/saturation per window.
// Define X_DELAY_LINE_MEAS_BUBBLE_EN for the bubble-tolerant popcount decoder (default: priority encoder).
module x_delay_line_meas #(
   parameter  int unsigned WIDTH    = 32,
   parameter  int unsigned WIN_LOG2 = 8,
   parameter  int unsigned WARMUP   = 4,
   localparam int unsigned PW       = $clog2(WIDTH + 1),
   localparam int unsigned SATW     = WIN_LOG2 + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_clear,
   output logic [PW-1:0]    o_pos,
   output logic [PW-1:0]    o_min,
   output logic [PW-1:0]    o_max,
   output logic [PW-1:0]    o_avg,
   output logic [SATW-1:0]  o_sat_cnt,
   output logic             o_valid
);

   localparam int unsigned SW    = PW + WIN_LOG2;
   localparam int unsigned WCW   = $clog2(WARMUP + 1);
   localparam int unsigned CW    = (WIN_LOG2 > WCW) ? WIN_LOG2 : WCW;
   localparam int unsigned LAST  = (1 << WIN_LOG2) - 1;

   typedef enum logic {WARM, ACCUM} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            pos_vld_q;
   logic [PW-1:0]   pos_q, pos_d;
   logic [PW-1:0]   min_q, min_d, max_q, max_d, avg_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [SATW-1:0] sat_q, sat_d;
   logic [PW-1:0]   omin_q, omax_q, oavg_q;
   logic [SATW-1:0] osat_q;
   logic            valid_q;

   // Edge position relative to this period's launch value i_data[0]
   always_comb begin
      pos_d = PW'(WIDTH);
`ifdef X_DELAY_LINE_MEAS_BUBBLE_EN
      pos_d = '0;
      for (int i = 0; i < int'(WIDTH); i++)
         pos_d = pos_d + PW'(i_data[i] == i_data[0]);
`else
      for (int i = int'(WIDTH) - 1; i >= 1; i--)
         if (i_data[i] != i_data[0]) pos_d = PW'(i);
`endif
   end

   // Accumulators with the current registered position folded in
   always_comb begin
      min_d = (pos_q < min_q) ? pos_q : min_q;
      max_d = (pos_q > max_q) ? pos_q : max_q;
      sum_d = sum_q + SW'(pos_q);
      sat_d = sat_q + SATW'(pos_q == PW'(WIDTH));
      avg_d = PW'(sum_d >> WIN_LOG2);
   end

   // Measurement FSM; consumes o_pos one cycle after its i_data sample
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= WARM;
         cnt_q     <= '0;
         pos_vld_q <= 1'b0;
         pos_q     <= '0;
         min_q     <= PW'(WIDTH);
         max_q     <= '0;
         sum_q     <= '0;
         sat_q     <= '0;
         omin_q    <= '0;
         omax_q    <= '0;
         oavg_q    <= '0;
         osat_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         pos_q     <= pos_d;
         pos_vld_q <= 1'b1;
         valid_q   <= 1'b0;
         if (i_clear) begin
            // Also drops the sample already in o_pos so warmup counts only post-clear data
            state_q   <= WARM;
            cnt_q     <= '0;
            pos_vld_q <= 1'b0;
         end else if (pos_vld_q) begin
            case (state_q)
               WARM: begin
                  if (cnt_q == CW'(WARMUP - 1)) begin
                     state_q <= ACCUM;
                     cnt_q   <= '0;
                     min_q   <= PW'(WIDTH);
                     max_q   <= '0;
                     sum_q   <= '0;
                     sat_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ACCUM: begin
                  if (cnt_q == CW'(LAST)) begin
                     omin_q  <= min_d;
                     omax_q  <= max_d;
                     oavg_q  <= avg_d;
                     osat_q  <= sat_d;
                     valid_q <= 1'b1;
                     cnt_q   <= '0;
                     min_q   <= PW'(WIDTH);
                     max_q   <= '0;
                     sum_q   <= '0;
                     sat_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                     min_q <= min_d;
                     max_q <= max_d;
                     sum_q <= sum_d;
                     sat_q <= sat_d;
                  end
               end
               default: state_q <= WARM;
            endcase
         end
      end
   end

   assign o_pos     = pos_q;
   assign o_min     = omin_q;
   assign o_max     = omax_q;
   assign o_avg     = oavg_q;
   assign o_sat_cnt = osat_q;
   assign o_valid   = valid_q;

endmodule

// File: tb/tb_x_delay_line_meas.sv
// Directed self-checking bench for x_delay_line_meas (WIDTH=32, WIN_LOG2=4, WARMUP=4).
module tb_x_delay_line_meas;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned WIN_LOG2 = 4;
   localparam int unsigned WARMUP   = 4;
   localparam int unsigned PW       = 6;
   localparam int unsigned SATW     = 5;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [WIDTH-1:0] i_data;
   logic             i_clear;
   logic [PW-1:0]    o_pos, o_min, o_max, o_avg;
   logic [SATW-1:0]  o_sat_cnt;
   logic             o_valid;

   int checks = 0;
   int errors = 0;

   x_delay_line_meas #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2), .WARMUP(WARMUP)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_data    (i_data),
      .i_clear   (i_clear),
      .o_pos     (o_pos),
      .o_min     (o_min),
      .o_max     (o_max),
      .o_avg     (o_avg),
      .o_sat_cnt (o_sat_cnt),
      .o_valid   (o_valid)
   );

   always #5 i_clk = ~i_clk;

   // Present one sample for one cycle, then sample outputs just after the edge
   task automatic cyc(input logic [WIDTH-1:0] d, input logic clr);
      i_data  = d;
      i_clear = clr;
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst   = 1'b1;
      i_data  = '0;
      i_clear = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
   endtask

   function automatic logic [WIDTH-1:0] spread_word(input int n);
      return (n % 2 == 0) ? 32'h0000_00FF : 32'hFF00_0000;
   endfunction

   function automatic logic [WIDTH-1:0] sat_word(input int n);
      return (n % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++;
      if ({o_pos, o_min, o_max, o_avg, o_sat_cnt, o_valid} !== '0) begin
         errors++;
         $display("FAIL reset_values: got pos=%0d min=%0d max=%0d avg=%0d sat=%0d valid=%0b expected all 0",
                  o_pos, o_min, o_max, o_avg, o_sat_cnt, o_valid);
      end
   endtask

   task automatic test_clean();
      logic exp_v;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         cyc((n % 2 == 0) ? 32'h0000_FFFF : 32'hFFFF_0000, 1'b0);
         exp_v = (n == 20) || (n == 36);
         checks++;
         if (o_pos !== 6'd16) begin
            errors++;
            $display("FAIL clean_pos n=%0d: got %0d expected 16", n, o_pos);
         end
         checks++;
         if (o_valid !== exp_v) begin
            errors++;
            $display("FAIL clean_valid n=%0d: got %0b expected %0b", n, o_valid, exp_v);
         end
         if (exp_v) begin
            checks++;
            if ({o_min, o_max, o_avg, o_sat_cnt} !== {6'd16, 6'd16, 6'd16, 5'd0}) begin
               errors++;
               $display("FAIL clean_result n=%0d: got min=%0d max=%0d avg=%0d sat=%0d expected 16/16/16/0",
                        n, o_min, o_max, o_avg, o_sat_cnt);
            end
         end
      end
   endtask

   task automatic test_saturation();
      logic exp_v;
      do_reset();
      for (int n = 0; n < 21; n++) begin
         cyc(sat_word(n), 1'b0);
         exp_v = (n == 20);
         checks++;
         if (o_pos !== 6'd32) begin
            errors++;
            $display("FAIL sat_pos n=%0d: got %0d expected 32", n, o_pos);
         end
         checks++;
         if (o_valid !== exp_v) begin
            errors++;
            $display("FAIL sat_valid n=%0d: got %0b expected %0b", n, o_valid, exp_v);
         end
      end
      checks++;
      if ({o_min, o_max, o_avg, o_sat_cnt} !== {6'd32, 6'd32, 6'd32, 5'd16}) begin
         errors++;
         $display("FAIL sat_result: got min=%0d max=%0d avg=%0d sat=%0d expected 32/32/32/16",
                  o_min, o_max, o_avg, o_sat_cnt);
      end
   endtask

   task automatic test_spread();
      logic exp_v;
      logic [PW-1:0] exp_pos;
      do_reset();
      for (int n = 0; n < 24; n++) begin
         cyc(spread_word(n), 1'b0);
         exp_v   = (n == 20);
         exp_pos = (n % 2 == 0) ? 6'd8 : 6'd24;
         checks++;
         if (o_pos !== exp_pos) begin
            errors++;
            $display("FAIL spread_pos n=%0d: got %0d expected %0d", n, o_pos, exp_pos);
         end
         checks++;
         if (o_valid !== exp_v) begin
            errors++;
            $display("FAIL spread_valid n=%0d: got %0b expected %0b", n, o_valid, exp_v);
         end
         if (n >= 20) begin
            checks++;
            if ({o_min, o_max, o_avg, o_sat_cnt} !== {6'd8, 6'd24, 6'd16, 5'd0}) begin
               errors++;
               $display("FAIL spread_result n=%0d: got min=%0d max=%0d avg=%0d sat=%0d expected 8/24/16/0",
                        n, o_min, o_max, o_avg, o_sat_cnt);
            end
         end
      end
   endtask

   task automatic test_bubble();
      logic [PW-1:0] exp_a, exp_b;
`ifdef X_DELAY_LINE_MEAS_BUBBLE_EN
      exp_a = 6'd15;
      exp_b = 6'd15;
`else
      exp_a = 6'd8;
      exp_b = 6'd8;
`endif
      cyc(32'h0000_FEFF, 1'b0);
      checks++;
      if (o_pos !== exp_a) begin
         errors++;
         $display("FAIL bubble_r1: got %0d expected %0d", o_pos, exp_a);
      end
      cyc(32'hFFFF_0100, 1'b0);
      checks++;
      if (o_pos !== exp_b) begin
         errors++;
         $display("FAIL bubble_r0: got %0d expected %0d", o_pos, exp_b);
      end
   endtask

   task automatic test_clear();
      logic exp_v;
      do_reset();
      for (int n = 0; n < 58; n++) begin
         cyc((n < 20) ? spread_word(n) : sat_word(n), n == 35);
         exp_v = (n == 20) || (n == 56);
         checks++;
         if (o_valid !== exp_v) begin
            errors++;
            $display("FAIL clear_valid n=%0d: got %0b expected %0b", n, o_valid, exp_v);
         end
         if (n >= 20 && n < 56) begin
            checks++;
            if ({o_min, o_max, o_avg, o_sat_cnt} !== {6'd8, 6'd24, 6'd16, 5'd0}) begin
               errors++;
               $display("FAIL clear_hold n=%0d: got min=%0d max=%0d avg=%0d sat=%0d expected 8/24/16/0",
                        n, o_min, o_max, o_avg, o_sat_cnt);
            end
         end
      end
      checks++;
      if ({o_min, o_max, o_avg, o_sat_cnt} !== {6'd32, 6'd32, 6'd32, 5'd16}) begin
         errors++;
         $display("FAIL clear_result: got min=%0d max=%0d avg=%0d sat=%0d expected 32/32/32/16",
                  o_min, o_max, o_avg, o_sat_cnt);
      end
   endtask

   task automatic test_async_reset();
      logic exp_v;
      do_reset();
      for (int n = 0; n < 25; n++) cyc(spread_word(n), 1'b0);
      checks++;
      if (o_max !== 6'd24) begin
         errors++;
         $display("FAIL arst_pre: got max=%0d expected 24", o_max);
      end
      #3;
      i_rst = 1'b1;
      #1;
      checks++;
      if ({o_pos, o_min, o_max, o_avg, o_sat_cnt, o_valid} !== '0) begin
         errors++;
         $display("FAIL arst_zero: got pos=%0d min=%0d max=%0d avg=%0d sat=%0d valid=%0b expected all 0",
                  o_pos, o_min, o_max, o_avg, o_sat_cnt, o_valid);
      end
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      for (int n = 0; n < 21; n++) begin
         cyc((n % 2 == 0) ? 32'h0000_FFFF : 32'hFFFF_0000, 1'b0);
         exp_v = (n == 20);
         checks++;
         if (o_valid !== exp_v) begin
            errors++;
            $display("FAIL arst_valid n=%0d: got %0b expected %0b", n, o_valid, exp_v);
         end
      end
      checks++;
      if ({o_min, o_max, o_avg, o_sat_cnt} !== {6'd16, 6'd16, 6'd16, 5'd0}) begin
         errors++;
         $display("FAIL arst_result: got min=%0d max=%0d avg=%0d sat=%0d expected 16/16/16/0",
                  o_min, o_max, o_avg, o_sat_cnt);
      end
   endtask

   initial begin
      i_rst   = 1'b1;
      i_data  = '0;
      i_clear = 1'b0;
      test_reset();
      test_clean();
      test_saturation();
      test_spread();
      test_bubble();
      test_clear();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
